top_pattern_sequencer: RTL

Controller that sequences the three-operand `top` datapath (in1/in2/in3 -> out1) through an exhaustive nested pattern sweep. It issues operands, tracks in-flight results across a fixed datapath latency, and buffers each captured out1 in a small result FIFO. Results are handed downstream on a valid/ready stream, and a running MISR signature is kept over all results. It replaces the free-running stimulus loop with a backpressure-aware, restartable, abortable scheduler.

---
 rtl/top_seq_pkg.sv | 35 +++
 rtl/top_pattern_sequencer_fifo.sv | 64 ++++++
 rtl/top_pattern_sequencer.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/top_seq_pkg.sv
// Shared types and helpers for the pattern sequencer.
//   seq_state_t : controller state encoding
//   idx_width() : width of the packed {i,j,k} pattern index for a counter width
//   misr_next() : one MISR step, rotate-left by one within w bits then XOR data
package top_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_t;

  localparam int unsigned CNT_W_DEFAULT = 4;
  localparam int unsigned IDX_W_DEFAULT = 3 * CNT_W_DEFAULT;

  function automatic int unsigned idx_width(input int unsigned cnt_w);
    return 3 * cnt_w;
  endfunction

  // Operates on a 64-bit container so one function serves any result width
  // up to 64; w is a constant at every call site, so this folds to wiring.
  function automatic logic [63:0] misr_next(input logic [63:0] sig,
                                            input logic [63:0] data,
                                            input int unsigned w);
    logic [63:0] mask;
    logic [63:0] sig_m;
    logic [63:0] rot;
    mask  = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    sig_m = sig & mask;
    rot   = ((sig_m << 1) | (sig_m >> (w - 1))) & mask;
    return rot ^ (data & mask);
  endfunction

endpackage

// File: rtl/top_pattern_sequencer_fifo.sv
// seq_result_fifo: synchronous FIFO holding {result, pattern index} entries.
// Ports:
//   clk, rst       clock and synchronous active-high reset
//   flush          synchronous empty (pointers and count cleared)
//   push/push_data write one entry
//   pop            consume the head entry
//   rd_data        head entry (stable until popped)
//   rd_valid       FIFO not empty
//   count          current occupancy
module seq_result_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  output logic [W-1:0]               rd_data,
  output logic                       rd_valid,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = $clog2(DEPTH + 1);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign rd_valid = (count != '0);
  assign rd_data  = mem[rd_ptr];
  assign pop_ok   = pop && rd_valid;
  // A push into a full FIFO is accepted only when the head leaves this cycle.
  assign push_ok  = push && ((count < CW'(DEPTH)) || pop_ok);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
      if (pop_ok)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush && push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/top_pattern_sequencer.sv
// top_pattern_sequencer: drives the three-operand datapath through every
// {i,j,k} pattern, captures each result after DUT_LAT cycles into a result
// FIFO, streams results out on valid/ready and folds them into a MISR.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start, abort             sweep request / cancel-and-flush
//   in1, in2, in3            operands (zero-extended i, j, k)
//   dut_out1                 datapath result
//   res_valid/ready/data/idx result stream, idx = {i,j,k} of the pattern
//   busy, done, signature    status and running MISR
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | waiting for start, nothing in flight
// ST_RUN   | issuing patterns whenever FIFO credit allows
// ST_DRAIN | last pattern issued, waiting for pipe and FIFO to empty
// ST_DONE  | sweep complete, signature held until restart
module top_pattern_sequencer
  import top_seq_pkg::*;
#(
  parameter int CNT_W      = 4,
  parameter int IN_W       = 19,
  parameter int OUT_W      = 20,
  parameter int DUT_LAT    = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  output logic [IN_W-1:0]    in1,
  output logic [IN_W-1:0]    in2,
  output logic [IN_W-1:0]    in3,
  input  logic [OUT_W-1:0]   dut_out1,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [OUT_W-1:0]   res_data,
  output logic [3*CNT_W-1:0] res_idx,
  output logic               busy,
  output logic               done,
  output logic [OUT_W-1:0]   signature
);

  localparam int IDX_W  = int'(idx_width(CNT_W));
  localparam int CNT_FW = $clog2(FIFO_DEPTH + 1);
  localparam int OCC_W  = $clog2(FIFO_DEPTH + DUT_LAT + 1) + 1;

  if (DUT_LAT < 1 || DUT_LAT > 4) begin : g_bad_lat
    $error("top_pattern_sequencer: DUT_LAT must be within 1..4");
  end
  if (FIFO_DEPTH < DUT_LAT + 1) begin : g_bad_depth
    $error("top_pattern_sequencer: FIFO_DEPTH must be at least DUT_LAT+1");
  end

  seq_state_t       state;
  logic [IDX_W-1:0] cnt;
  logic [DUT_LAT-1:0] pipe_v;
  logic [IDX_W-1:0] pipe_tag [DUT_LAT];
  logic [OUT_W-1:0] sig;

  logic [CNT_FW-1:0]      fifo_count;
  logic                   fifo_valid;
  logic [OUT_W+IDX_W-1:0] fifo_rd;

  logic             pop;
  logic             push;
  logic             issue;
  logic             credit;
  logic             last_issue;
  logic [OCC_W-1:0] in_flight;
  logic [OCC_W-1:0] occupancy;

  assign pop  = fifo_valid && res_ready;
  assign push = pipe_v[DUT_LAT-1];

  always_comb begin
    in_flight = '0;
    for (int s = 0; s < DUT_LAT; s++) in_flight = in_flight + OCC_W'(pipe_v[s]);
  end

  // Everything in the pipe is already owed a FIFO slot; a pop this cycle
  // releases one, so the FIFO can never overflow.
  assign occupancy  = in_flight + OCC_W'(fifo_count) - OCC_W'(pop);
  assign credit     = (occupancy < OCC_W'(FIFO_DEPTH));
  assign issue      = (state == ST_RUN) && credit && !abort;
  assign last_issue = issue && (cnt == '1);

  always_ff @(posedge clk) begin
    if (rst || abort) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      in1    <= '0;
      in2    <= '0;
      in3    <= '0;
      pipe_v <= '0;
      for (int s = 0; s < DUT_LAT; s++) pipe_tag[s] <= '0;
      sig    <= '0;
    end else begin
      pipe_v[0] <= issue;
      for (int s = 1; s < DUT_LAT; s++) begin
        pipe_v[s]   <= pipe_v[s-1];
        pipe_tag[s] <= pipe_tag[s-1];
      end

      if (issue) begin
        pipe_tag[0] <= cnt;
        in1 <= IN_W'(cnt[IDX_W-1 -: CNT_W]);
        in2 <= IN_W'(cnt[2*CNT_W-1 -: CNT_W]);
        in3 <= IN_W'(cnt[CNT_W-1:0]);
        // {i,j,k} as one binary counter gives k-fastest order with carries.
        cnt <= cnt + 1'b1;
      end

      if (pop) sig <= OUT_W'(misr_next(64'(sig), 64'(res_data), OUT_W));

      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state <= ST_RUN;
            cnt   <= '0;
            sig   <= '0;
          end
        end
        ST_RUN: begin
          if (last_issue) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (in_flight == '0 && fifo_count == '0) state <= ST_DONE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  seq_result_fifo #(
    .W     (OUT_W + IDX_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (abort),
    .push      (push),
    .push_data ({dut_out1, pipe_tag[DUT_LAT-1]}),
    .pop       (pop),
    .rd_data   (fifo_rd),
    .rd_valid  (fifo_valid),
    .count     (fifo_count)
  );

  assign res_valid = fifo_valid;
  assign res_data  = fifo_rd[OUT_W+IDX_W-1:IDX_W];
  assign res_idx   = fifo_rd[IDX_W-1:0];
  assign busy      = (state == ST_RUN) || (state == ST_DRAIN);
  assign done      = (state == ST_DONE);
  assign signature = sig;

endmodule
